// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
//
// Sequential unsigned integer divider using radix-2 restoring division. It
// retires one quotient bit per clock and holds one operation in flight.
// Operands enter through a valid/ready handshake. The result leaves through a
// second valid/ready handshake and is held while downstream applies
// backpressure.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     dividend/divisor valid
//   in_ready     block can accept an operation (high only when idle)
//   dividend     unsigned dividend  [WIDTH-1:0]
//   divisor      unsigned divisor   [WIDTH-1:0]
//   out_valid    result valid, held until out_ready
//   out_ready    downstream accepts the result
//   quotient     unsigned quotient  [WIDTH-1:0]
//   remainder    unsigned remainder [WIDTH-1:0]
//   div_by_zero  result came from a zero divisor:
//                quotient = all ones, remainder = dividend
//
// Latency from the accepting edge to out_valid is WIDTH cycles for a nonzero
// divisor and 1 cycle for a zero divisor. With out_ready held high, the
// divider returns one result every WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // The partial remainder stays below the divisor, so its extra sign bit is
  // always zero between iterations. Only WIDTH bits are stored. The
  // WIDTH+1-bit form exists only inside the trial subtraction.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic             zdiv;

  logic [WIDTH:0]        shifted;
  logic signed [WIDTH:0] t;
  logic [WIDTH-1:0]      r_step;
  logic [WIDTH-1:0]      q_step;
  logic                  accept;
  logic                  last;

  assign accept = in_valid && in_ready;
  assign last   = (state == CALC) && (cnt == CW'(1));

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor. Keep the difference only if it is non-negative.
  // The difference always lies in [-D, D-1], so the WIDTH+1-bit modular
  // result has the correct sign bit.
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    t       = $signed(shifted - {1'b0, d});
    r_step  = shifted[WIDTH-1:0];
    q_step  = {q[WIDTH-2:0], 1'b0};
    if (t >= 0) begin
      r_step = t[WIDTH-1:0];
      q_step = {q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      zdiv        <= 1'b0;
    end else begin
      state     <= state_nxt;
      // The handshake flags are registered from the next state. As a result,
      // in_ready rises one cycle after reset release or after a result
      // handshake, and never in the same cycle as the handshake.
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            d           <= divisor;
            q           <= dividend;
            r           <= '0;
            div_by_zero <= 1'b0;
            zdiv        <= (divisor == '0);
            // A zero divisor makes a single pass through CALC with no
            // iteration, which gives the one-cycle result latency.
            cnt         <= (divisor == '0) ? CW'(1) : CW'(WIDTH);
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!zdiv) begin
            r <= r_step;
            q <= q_step;
          end
          if (last) begin
            if (zdiv) begin
              quotient    <= '1;
              remainder   <= q;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= q_step;
              remainder   <= r_step;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_restoring_divider
//
// Scoreboard bench for restoring_divider (WIDTH=16). The stimulus process
// pushes the expected result for each accepted operation. A monitor pops and
// compares on every result handshake and also checks the arithmetic
// invariant for nonzero divisors.
// ---------------------------------------------------------------------------
module tb_restoring_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   issued  = 0;
  int   results = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result handshake happens on the next rising edge whenever
  // out_valid and out_ready are both high at the falling edge.
  exp_t        mon_e;
  logic [63:0] mon_p;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result quotient=%0h remainder=%0h required=no result",
                 quotient, remainder);
      end else begin
        mon_e = sb.pop_front();
        results++;
        chk("quotient", 64'(quotient), 64'(mon_e.q));
        chk("remainder", 64'(remainder), 64'(mon_e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.z));
        if (!mon_e.z) begin
          mon_p = 64'(quotient) * 64'(mon_e.b) + 64'(remainder);
          chk("invariant_q*d+r", mon_p, 64'(mon_e.a));
          chk("rem_lt_div", 64'(remainder < mon_e.b), 64'd1);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int n;
    n = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=0 required=1");
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{a, b, eq, er, ez});
    issued++;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  // Returns the number of cycles from the accepting edge until out_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] a, b, eq, er;
    logic ez;
    logic hs, hs_pre;
    int n;

    // Reset state.
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_quotient", 64'(quotient), 0);
    chk("rst_remainder", 64'(remainder), 0);
    chk("rst_div_by_zero", 64'(div_by_zero), 0);
    rst_n = 1'b1;
    step();
    chk("in_ready_after_reset", 64'(in_ready), 1);

    // 100 / 7 with a 16-cycle latency.
    out_ready = 1'b1;
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    wait_valid(lat);
    chk("latency_100_7", 64'(lat), 64'd16);
    drain();

    // Zero divisor with a 1-cycle latency.
    issue(16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_valid(lat);
    chk("latency_div0", 64'(lat), 64'd1);
    drain();

    // Boundary operands.
    issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
    issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
    issue(16'd0, 16'd13, 16'd0, 16'd0, 1'b0);
    wait_valid(lat);
    chk("latency_zero_dividend", 64'(lat), 64'd16);
    drain();

    // Backpressure. Operands presented while busy must be ignored.
    out_ready = 1'b0;
    issue(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0);
    in_valid = 1'b1;
    dividend = 16'd7;
    divisor  = 16'd2;
    wait_valid(lat);
    chk("bp_out_valid_seen", 64'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_quotient_hold", 64'(quotient), 64'd30);
      chk("bp_remainder_hold", 64'(remainder), 64'd10);
      chk("bp_in_ready_low", 64'(in_ready), 0);
      chk("bp_out_valid_hold", 64'(out_valid), 1);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", 64'(in_ready), 1);
    chk("bp_release_out_valid", 64'(out_valid), 0);

    // Asynchronous reset during CALC aborts the operation.
    issue(16'd500, 16'd7, 16'd71, 16'd3, 1'b0);
    repeat (7) step();
    rst_n = 1'b0;
    #2;
    chk("abort_out_valid", 64'(out_valid), 0);
    chk("abort_in_ready", 64'(in_ready), 0);
    chk("abort_quotient", 64'(quotient), 0);
    chk("abort_remainder", 64'(remainder), 0);
    chk("abort_div_by_zero", 64'(div_by_zero), 0);
    issued -= sb.size();
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    issue(16'd81, 16'd9, 16'd9, 16'd0, 1'b0);
    drain();

    // Random operands with random input gaps and output stalls.
    for (int k = 0; k < 2000; k++) begin
      repeat ($urandom_range(0, 2)) step();
      a = W'($urandom);
      if ($urandom_range(0, 19) == 0) b = '0;
      else b = W'($urandom >> $urandom_range(0, 15));
      ez = (b == '0);
      eq = ez ? '1 : a / b;
      er = ez ? a : a % b;
      issue(a, b, eq, er, ez);
      n = 0;
      hs = 1'b0;
      while (!hs && n < 100) begin
        out_ready = ($urandom_range(0, 2) != 0);
        hs_pre = out_valid && out_ready;
        step();
        hs = hs_pre;
        n++;
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL result_timeout op=%0d required=handshake", k);
      end
    end
    out_ready = 1'b1;
    drain();
    chk("result_count", 64'(results), 64'(issued));
    chk("scoreboard_empty", 64'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
